eth_fifo_gmii_tx: RTL and testbench
===================================

# eth_fifo_gmii_tx

Downstream consumer of the 32-bit Ethernet prefetch FIFO: pops words over the FIFO's `rd_en`/`rd_vld` handshake and serializes them MSB-byte-first onto an 8-bit GMII transmit interface. Each frame consists of preamble, SFD, a fixed number of payload words, an optional FCS and an inter-frame gap. It sits between the eth_fifo read port and the GMII TX pins of the ethernet test design.

## Interface
- `FRAME_WORDS`, 16, payload words per frame (1..4095); payload bytes = 4*FRAME_WORDS
- `IFG_CYCLES`, 12, idle cycles with `gmii_tx_en` low after each frame (>=1)
- `clk`  in  1  single clock; FIFO read clock and GMII TX clock
- `rst_n`  in  1  reset, synchronous, active-low
- `fifo_rd_data`  in  32  FIFO output word; valid when `fifo_rd_vld`
- `fifo_rd_vld`  in  1  FIFO has a word presented
- `fifo_rd_en`  out  1  pop; word consumed when `fifo_rd_en & fifo_rd_vld`
- `gmii_txd`  out  8  transmit byte
- `gmii_tx_en`  out  1  byte valid
- `gmii_tx_er`  out  1  transmit error (underrun marker)
- `busy`  out  1  high in any state other than IDLE
- `frame_cnt`  out  16  completed frames, wraps
- `underrun_cnt`  out  8  aborted frames, saturates at 255

## Operation
- States: IDLE, PREAMBLE, SFD, PAYLOAD, FCS (only with CRC), IFG.
- IDLE: when `fifo_rd_vld`=1, go to PREAMBLE. No pop in IDLE.
- PREAMBLE: 7 bytes 0x55; byte counter 0..6, then SFD.
- SFD: 1 byte 0xD5. In this cycle, pop the first word into a 32-bit shift register: `fifo_rd_en`=`fifo_rd_vld`.
- PAYLOAD: output `shift[31:24]`, then shift left by 8; byte index 0..3, word counter 0..FRAME_WORDS-1.
  - At byte index 3 of any word except the last, pop the next word: `fifo_rd_en`=`fifo_rd_vld`.
  - After byte 3 of the last word: go to FCS if compiled in, else IFG.
- FCS: 4 bytes, then IFG.
- IFG: `gmii_tx_en`=0, `gmii_txd`=0 for IFG_CYCLES cycles, then IDLE.
- `frame_cnt` increments on entry to IFG from a completed frame.
- Underrun: a pop is needed (SFD, or byte index 3 of a non-last word) and `fifo_rd_vld`=0.
  - The next output byte is 0x00 with `gmii_tx_en`=1 and `gmii_tx_er`=1.
  - The following cycle enters IFG.
  - `underrun_cnt` increments; `frame_cnt` does not.
  - No further pops occur for that frame.
- `fifo_rd_en` is combinational from state and counters. It never asserts outside SFD or PAYLOAD, and never when `fifo_rd_vld`=0.

## Timing
- All GMII outputs and the counters are registered.
- Reset: on any `clk` edge with `rst_n`=0, the block enters IDLE, zeroes all counters, and the shift register and CRC return to their reset values. The next cycle shows:
  - `gmii_txd`=0, `gmii_tx_en`=0, `gmii_tx_er`=0
  - `busy`=0, `frame_cnt`=0, `underrun_cnt`=0, `fifo_rd_en`=0
- Reset mid-frame truncates the frame immediately. FIFO contents are untouched.
- Frame start: `fifo_rd_vld` seen high in IDLE at edge N gives:
  - preamble on cycles N+1..N+7
  - SFD on N+8 (first pop occurs in this cycle)
  - payload on N+9..N+8+4*FRAME_WORDS
  - FCS on the next 4 cycles if compiled in
  - then IFG_CYCLES low cycles
- Back-to-back frames: total period is 8+4*FRAME_WORDS(+4)+IFG_CYCLES cycles.
- Pop cadence: exactly one pop per 4 payload cycles.

## Configuration
- Macro `ETH_TX_CRC_EN`, defined: the FCS state is present.
  - CRC-32 uses reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte, over payload bytes only.
  - FCS = ~crc, sent low byte first.
  - The CRC register resets to 0xFFFFFFFF in SFD.
- Macro `ETH_TX_CRC_EN`, undefined: no FCS state and no CRC logic; PAYLOAD goes directly to IFG.

## Structure
- Package `eth_tx_pkg` holds:
  - state enum
  - `PREAMBLE_BYTE`=8'h55, `SFD_BYTE`=8'hD5, `PREAMBLE_LEN`=7
  - `CRC_POLY`=32'hEDB88320, `CRC_INIT`=32'hFFFFFFFF, `CRC_RESIDUE`=32'hDEBB20E3
- One sub-module, `eth_crc32_d8`: combinational next-CRC from the current CRC and a data byte. It is instantiated only under `ETH_TX_CRC_EN`.

## Test plan
- Reset mid-payload (`rst_n`=0 for 1 cycle) -> next cycle all outputs 0 and state IDLE; the FIFO word presented then is not popped.
- FRAME_WORDS=2, FIFO holds 0x11223344, 0x55667788 -> `gmii_txd` = 55×7, D5, 11 22 33 44 55 66 77 88, then `gmii_tx_en` low for 12 cycles; `frame_cnt`=1; exactly 2 pops.
- FIFO preloaded with 3 frames of data -> frames back-to-back with period 8+4*FRAME_WORDS(+4)+12 cycles; `frame_cnt`=3; `busy` low only after the last IFG.
- `fifo_rd_vld` drops before word 2 of a 4-word frame -> bytes of words 0 and 1 sent, then one byte 0x00 with `tx_er`=1, then IFG; `underrun_cnt`=1, `frame_cnt` unchanged.
- Underrun forced 300 times -> `underrun_cnt` holds 255.
- With `ETH_TX_CRC_EN`, random payloads -> CRC recomputed by the bench over payload+FCS equals `CRC_RESIDUE` 0xDEBB20E3; without the macro, frame length is 4 bytes shorter.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit serializer.
// The FCS state only exists when ETH_TX_CRC_EN is defined.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
`ifdef ETH_TX_CRC_EN
        ST_FCS      = 3'd4,
`endif
        ST_IFG      = 3'd5
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 step: folds one data byte, LSB first, into the
// current reflected CRC register. Only used when ETH_TX_CRC_EN is defined.
module eth_crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Bit-serial reflected LFSR unrolled over the eight data bits.
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_fifo_gmii_tx.sv
// Pops 32-bit words from the prefetch FIFO and serializes them MSB byte
// first onto GMII TX as preamble, SFD, payload, optional FCS and IFG.
// Define ETH_TX_CRC_EN to append a CRC-32 FCS after the payload.
module eth_fifo_gmii_tx
    import eth_tx_pkg::*;
#(
    parameter int FRAME_WORDS = 16,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fifo_rd_data,
    input  logic        fifo_rd_vld,
    output logic        fifo_rd_en,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  underrun_cnt
);

    localparam logic [11:0] WORD_LAST = 12'(FRAME_WORDS - 1);
    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);

    tx_state_t   state, state_d;
    logic [15:0] cnt, cnt_d;            // preamble / FCS / IFG cycle counter
    logic [1:0]  byte_idx, byte_idx_d;
    logic [11:0] word_cnt, word_cnt_d;
    logic [31:0] shift, shift_d;
    logic        abort, abort_d;        // error byte is on the wire this cycle
    logic [7:0]  txd_d;
    logic        tx_en_d, tx_er_d;
    logic        frame_inc, underrun_inc;

    logic        last_word;
    logic        pop_needed;
    logic        underrun;

    assign last_word  = (word_cnt == WORD_LAST);
    assign pop_needed = (state == ST_SFD) ||
                        ((state == ST_PAYLOAD) && !abort && (byte_idx == 2'd3) && !last_word);
    assign underrun   = pop_needed && !fifo_rd_vld;
    // Gated by rst_n so a reset cycle never consumes a FIFO word.
    assign fifo_rd_en = rst_n && pop_needed && fifo_rd_vld;
    assign busy       = (state != ST_IDLE);

`ifdef ETH_TX_CRC_EN
    logic [31:0] crc, crc_d, crc_step;

    // The byte currently on gmii_txd is the one folded into the CRC.
    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (gmii_txd),
        .crc_out (crc_step)
    );

    // CRC restarts at SFD, accumulates payload, then shifts out as FCS.
    always_comb begin
        crc_d = crc;
        case (state)
            ST_SFD:     crc_d = CRC_INIT;
            ST_PAYLOAD: if (!abort) crc_d = (byte_idx == 2'd3 && last_word) ? (crc_step >> 8) : crc_step;
            ST_FCS:     crc_d = crc >> 8;
            default:    crc_d = crc;
        endcase
    end

    // CRC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else begin
            crc <= crc_d;
        end
    end
`endif

    // Next-state and next-output logic; outputs are registered below so the
    // byte chosen here appears on the wire in the cycle after the edge.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path infers a latch.
        state_d      = state;
        cnt_d        = cnt;
        byte_idx_d   = byte_idx;
        word_cnt_d   = word_cnt;
        shift_d      = shift;
        abort_d      = abort;
        txd_d        = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_inc    = 1'b0;
        underrun_inc = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fifo_rd_vld) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = '0;
                    txd_d   = PREAMBLE_BYTE;
                    tx_en_d = 1'b1;
                end
            end

            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_d = ST_SFD;
                    txd_d   = SFD_BYTE;
                end else begin
                    cnt_d = cnt + 16'd1;
                    txd_d = PREAMBLE_BYTE;
                end
            end

            ST_SFD: begin
                state_d    = ST_PAYLOAD;
                tx_en_d    = 1'b1;
                byte_idx_d = '0;
                word_cnt_d = '0;
                if (underrun) begin
                    abort_d      = 1'b1;
                    tx_er_d      = 1'b1;
                    underrun_inc = 1'b1;
                end else begin
                    txd_d   = fifo_rd_data[31:24];
                    shift_d = {fifo_rd_data[23:0], 8'h00};
                end
            end

            ST_PAYLOAD: begin
                if (abort) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end else if (byte_idx != 2'd3) begin
                    byte_idx_d = byte_idx + 2'd1;
                    txd_d      = shift[31:24];
                    shift_d    = {shift[23:0], 8'h00};
                    tx_en_d    = 1'b1;
                end else if (!last_word) begin
                    tx_en_d    = 1'b1;
                    byte_idx_d = '0;
                    word_cnt_d = word_cnt + 12'd1;
                    if (underrun) begin
                        abort_d      = 1'b1;
                        tx_er_d      = 1'b1;
                        underrun_inc = 1'b1;
                    end else begin
                        txd_d   = fifo_rd_data[31:24];
                        shift_d = {fifo_rd_data[23:0], 8'h00};
                    end
                end else begin
`ifdef ETH_TX_CRC_EN
                    state_d = ST_FCS;
                    cnt_d   = '0;
                    txd_d   = ~crc_step[7:0];
                    tx_en_d = 1'b1;
`else
                    state_d   = ST_IFG;
                    cnt_d     = '0;
                    frame_inc = 1'b1;
`endif
                end
            end

`ifdef ETH_TX_CRC_EN
            ST_FCS: begin
                if (cnt == 16'd3) begin
                    state_d   = ST_IFG;
                    cnt_d     = '0;
                    frame_inc = 1'b1;
                end else begin
                    cnt_d   = cnt + 16'd1;
                    txd_d   = ~crc[7:0];
                    tx_en_d = 1'b1;
                end
            end
`endif

            ST_IFG: begin
                // The last gap cycle doubles as the IDLE decision so
                // back-to-back frames keep exactly IFG_CYCLES low cycles.
                if (cnt == IFG_LAST) begin
                    if (fifo_rd_vld) begin
                        state_d = ST_PREAMBLE;
                        cnt_d   = '0;
                        txd_d   = PREAMBLE_BYTE;
                        tx_en_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath, GMII output and statistics registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            byte_idx     <= '0;
            word_cnt     <= '0;
            shift        <= '0;
            abort        <= 1'b0;
            gmii_txd     <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            byte_idx   <= byte_idx_d;
            word_cnt   <= word_cnt_d;
            shift      <= shift_d;
            abort      <= abort_d;
            gmii_txd   <= txd_d;
            gmii_tx_en <= tx_en_d;
            gmii_tx_er <= tx_er_d;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (underrun_inc && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_fifo_gmii_tx.sv
// Self-checking bench for eth_fifo_gmii_tx: FIFO model feeding the DUT,
// negedge monitor capturing GMII bytes, scoreboard of expected bytes.
// Works with or without ETH_TX_CRC_EN defined.
module tb_eth_fifo_gmii_tx;
    import eth_tx_pkg::*;

    localparam int FW  = 4;
    localparam int IFG = 12;
`ifdef ETH_TX_CRC_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif
    localparam int FRAME_LEN = 8 + 4 * FW + FCS_LEN;
    localparam int PERIOD    = FRAME_LEN + IFG;

    typedef logic [31:0] frame_t [FW];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_vld;
    logic        fifo_rd_en;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  underrun_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    eth_fifo_gmii_tx #(.FRAME_WORDS(FW), .IFG_CYCLES(IFG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by the tests, popped on rd_en & rd_vld.
    logic [31:0] fifo_mem [0:1023];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  pops   = 0;
    bit  vld_en = 1'b0;

    assign fifo_rd_vld  = vld_en && (wr_ptr != rd_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr % 1024];

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_rd_vld) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    // Monitor: captured bytes, frame start cycles, gap lengths, idle hygiene.
    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    int start_cyc [$];
    int gap_q [$];
    int cyc = 0;
    int low_run = 0;
    int idle_bad = 0;
    bit en_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (gmii_tx_en === 1'b1) begin
            obs_q.push_back({gmii_tx_er, gmii_txd});
            if (!en_prev) start_cyc.push_back(cyc);
        end else if (gmii_txd !== 8'h00 || gmii_tx_er !== 1'b0) begin
            idle_bad++;
        end
        if (busy === 1'b1 && gmii_tx_en !== 1'b1) begin
            low_run++;
        end else if (low_run != 0) begin
            gap_q.push_back(low_run);
            low_run = 0;
        end
        en_prev = (gmii_tx_en === 1'b1);
    end

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        start_cyc.delete();
        gap_q.delete();
    endtask

    task automatic push_header();
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
    endtask

    task automatic load_frame(input frame_t w);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        push_header();
        for (int i = 0; i < FW; i++) begin
            fifo_mem[wr_ptr % 1024] = w[i];
            wr_ptr++;
            for (int k = 0; k < 4; k++) begin
                b = w[i][31 - 8 * k -: 8];
                exp_q.push_back({1'b0, b});
                c = crc_model(c, b);
            end
        end
`ifdef ETH_TX_CRC_EN
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8 * k +: 8]});
`endif
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        repeat (2) @(negedge clk);
        while (busy !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_mis++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", tag, busy, k);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({gmii_txd, gmii_tx_en, gmii_tx_er} !== 10'h0) begin
            n_mis++;
            $display("FAIL reset_gmii: txd=%h en=%b er=%b, want 0", gmii_txd, gmii_tx_en, gmii_tx_er);
        end
        n_cmp++;
        if ({busy, fifo_rd_en} !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_ctrl: busy=%b rd_en=%b, want 0", busy, fifo_rd_en);
        end
        n_cmp++;
        if (frame_cnt !== 16'd0 || underrun_cnt !== 8'd0) begin
            n_mis++;
            $display("FAIL reset_cnt: frame_cnt=%0d underrun_cnt=%0d, want 0", frame_cnt, underrun_cnt);
        end
    endtask

    task automatic test_basic();
        frame_t w;
        w = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        clear_obs();
        load_frame(w);
        vld_en = 1'b1;
        wait_idle("basic");
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL basic_len: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_mis++;
                $display("FAIL basic_byte%0d: got er/txd=%h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (frame_cnt !== 16'd1) begin
            n_mis++;
            $display("FAIL basic_frame_cnt: got %0d, want 1", frame_cnt);
        end
        n_cmp++;
        if (pops != FW) begin
            n_mis++;
            $display("FAIL basic_pops: got %0d, want %0d", pops, FW);
        end
        n_cmp++;
        if (gap_q.size() != 1 || gap_q[0] != IFG) begin
            n_mis++;
            $display("FAIL basic_ifg: got %0d gaps first=%0d, want 1 gap of %0d", gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1, IFG);
        end
    endtask

    task automatic test_mid_reset();
        int pops0;
        int k;
        clear_obs();
        pops0 = pops;
        vld_en = 1'b1;
        for (int i = 0; i < FW; i++) begin
            fifo_mem[wr_ptr % 1024] = 32'hA0A0A000 + i;
            wr_ptr++;
        end
        k = 0;
        while (obs_q.size() < 12 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (obs_q.size() < 12) begin
            n_mis++;
            $display("FAIL midrst_start: got %0d bytes, want 12", obs_q.size());
        end
        // DUT is showing byte 3 of word 0, where it would otherwise pop word 1.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({gmii_txd, gmii_tx_en, gmii_tx_er, busy, fifo_rd_en} !== 12'h0) begin
            n_mis++;
            $display("FAIL midrst_outputs: txd=%h en=%b er=%b busy=%b rd_en=%b, want 0", gmii_txd, gmii_tx_en, gmii_tx_er, busy, fifo_rd_en);
        end
        n_cmp++;
        if (frame_cnt !== 16'd0 || underrun_cnt !== 8'd0) begin
            n_mis++;
            $display("FAIL midrst_cnt: frame_cnt=%0d underrun_cnt=%0d, want 0", frame_cnt, underrun_cnt);
        end
        n_cmp++;
        if (pops - pops0 != 1) begin
            n_mis++;
            $display("FAIL midrst_pops: got %0d, want 1", pops - pops0);
        end
        vld_en = 1'b0;
        rst_n  = 1'b1;
        wr_ptr = rd_ptr;
        repeat (2) @(negedge clk);
        clear_obs();
    endtask

    task automatic test_back_to_back();
        frame_t w;
        int pops0;
        clear_obs();
        pops0 = pops;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FW; i++) w[i] = $urandom();
            load_frame(w);
        end
        vld_en = 1'b1;
        wait_idle("b2b");
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL b2b_len: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_mis++;
                $display("FAIL b2b_byte%0d: got er/txd=%h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (start_cyc.size() != 3) begin
            n_mis++;
            $display("FAIL b2b_frames: got %0d starts, want 3", start_cyc.size());
        end
        for (int i = 1; i < start_cyc.size(); i++) begin
            n_cmp++;
            if (start_cyc[i] - start_cyc[i - 1] != PERIOD) begin
                n_mis++;
                $display("FAIL b2b_period%0d: got %0d cycles, want %0d", i, start_cyc[i] - start_cyc[i - 1], PERIOD);
            end
        end
        n_cmp++;
        if (frame_cnt !== 16'd3) begin
            n_mis++;
            $display("FAIL b2b_frame_cnt: got %0d, want 3", frame_cnt);
        end
        n_cmp++;
        if (pops - pops0 != 3 * FW) begin
            n_mis++;
            $display("FAIL b2b_pops: got %0d, want %0d", pops - pops0, 3 * FW);
        end
        n_cmp++;
        if (idle_bad != 0) begin
            n_mis++;
            $display("FAIL idle_lines: got %0d non-zero idle cycles, want 0", idle_bad);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] w0, w1;
        int pops0;
        w0 = 32'hCAFEBABE;
        w1 = 32'h01234567;
        clear_obs();
        pops0 = pops;
        push_header();
        fifo_mem[wr_ptr % 1024] = w0; wr_ptr++;
        fifo_mem[wr_ptr % 1024] = w1; wr_ptr++;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, w0[31 - 8 * k -: 8]});
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, w1[31 - 8 * k -: 8]});
        exp_q.push_back({1'b1, 8'h00});
        vld_en = 1'b1;
        wait_idle("underrun");
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL underrun_len: got %0d bytes, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_mis++;
                $display("FAIL underrun_byte%0d: got er/txd=%h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (underrun_cnt !== 8'd1 || frame_cnt !== 16'd3) begin
            n_mis++;
            $display("FAIL underrun_cnt: underrun_cnt=%0d frame_cnt=%0d, want 1 and 3", underrun_cnt, frame_cnt);
        end
        n_cmp++;
        if (pops - pops0 != 2) begin
            n_mis++;
            $display("FAIL underrun_pops: got %0d, want 2", pops - pops0);
        end
        n_cmp++;
        if (gap_q.size() != 1 || gap_q[0] != IFG) begin
            n_mis++;
            $display("FAIL underrun_ifg: got %0d gaps first=%0d, want 1 gap of %0d", gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1, IFG);
        end
    endtask

    task automatic test_underrun_saturate();
        vld_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            clear_obs();
            fifo_mem[wr_ptr % 1024] = 32'h5A5A0000 + i;
            wr_ptr++;
            wait_idle("sat");
            if (i == 252) begin
                n_cmp++;
                if (underrun_cnt !== 8'd254) begin
                    n_mis++;
                    $display("FAIL sat_254: got %0d, want 254", underrun_cnt);
                end
            end
        end
        n_cmp++;
        if (underrun_cnt !== 8'd255) begin
            n_mis++;
            $display("FAIL sat_255: got %0d, want 255", underrun_cnt);
        end
        n_cmp++;
        if (frame_cnt !== 16'd3) begin
            n_mis++;
            $display("FAIL sat_frame_cnt: got %0d, want 3", frame_cnt);
        end
    endtask

    task automatic test_fcs();
        frame_t w;
        logic [31:0] r;
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            for (int i = 0; i < FW; i++) w[i] = $urandom();
            load_frame(w);
            vld_en = 1'b1;
            wait_idle("fcs");
            n_cmp++;
            if (obs_q.size() != FRAME_LEN) begin
                n_mis++;
                $display("FAIL fcs_len%0d: got %0d bytes, want %0d", f, obs_q.size(), FRAME_LEN);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_mis++;
                    $display("FAIL fcs_byte%0d_%0d: got er/txd=%h, want %h", f, i, obs_q[i], exp_q[i]);
                end
            end
`ifdef ETH_TX_CRC_EN
            r = CRC_INIT;
            for (int i = 8; i < obs_q.size(); i++) r = crc_model(r, obs_q[i][7:0]);
            n_cmp++;
            if (r !== CRC_RESIDUE) begin
                n_mis++;
                $display("FAIL fcs_residue%0d: got %h, want %h", f, r, CRC_RESIDUE);
            end
`else
            r = 32'h0;
`endif
            n_cmp++;
            if (frame_cnt !== 16'(4 + f)) begin
                n_mis++;
                $display("FAIL fcs_frame_cnt%0d: got %0d, want %0d", f, frame_cnt, 4 + f);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_mid_reset();
        test_back_to_back();
        test_underrun();
        test_underrun_saturate();
        test_fcs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
